// File: rtl/interleave_n_pkg.sv
// interleave_n_pkg
//   Shared definitions for the N-channel interleaver: mode encodings and the
//   drain-state type used by the top level.
package interleave_n_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/interleave_n_next_chan.sv
// interleave_next_chan
//   Combinational search for the first set mask bit at or after a start
//   index, wrapping past NCH-1 back to index 0.
// Ports
//   mask_i   in  NCH  candidate channels
//   start_i  in  CW   search start index (must be < NCH)
//   idx_o    out CW   first set bit at/after start_i, with wrap
//   valid_o  out 1    mask_i had at least one bit set
module interleave_next_chan #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CW-1:0]  start_i,
  output logic [CW-1:0]  idx_o,
  output logic           valid_o
);

  // Scan from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[(int'(start_i) + i) % NCH]) begin
        idx_o   = CW'((int'(start_i) + i) % NCH);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interleave_n.sv
// interleave_n
//   Merges NCH parallel sample channels into one tagged word stream.
//   ROTATE: one word per strobe, cycling through active channels.
//   BURST : a strobe captures all channels; active ones drain on the
//           following clocks, lowest index first.
// Ports
//   clock, reset            clock / synchronous active-high reset
//   enable                  0 holds the block cleared (overrun kept)
//   init                    synchronous re-init, clears overrun too
//   data_in   [NCH*DW]      channel k at [k*DW +: DW]
//   strobe_in               input sample set valid
//   active_mask [NCH]       channel enables; all-zero means channel 0 only
//   mode                    0 rotate, 1 burst
//   data_out/chan_out       interleaved word and its source channel
//   strobe_out/first_out    word valid / word is the frame-start channel
//   overrun                 sticky: strobe dropped while a burst drained
//
// state    | meaning
// ST_IDLE  | no burst pending; strobes handled per mode input
// ST_DRAIN | burst captured; one word emitted per clock from rem
module interleave_n
  import interleave_n_pkg::*;
#(
  parameter  int DW  = 16,
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              init,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              strobe_in,
  input  logic [NCH-1:0]    active_mask,
  input  logic              mode,
  output logic [DW-1:0]     data_out,
  output logic [CW-1:0]     chan_out,
  output logic              strobe_out,
  output logic              first_out,
  output logic              overrun
);

  logic [NCH-1:0] m_eff;
  logic [DW-1:0]  ch_in [NCH];

  state_t         state_q, state_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]  shadow_q [NCH];
  logic [DW-1:0]  shadow_d [NCH];
  logic [NCH-1:0] rem_q, rem_d, rem_left;
  logic           first_pend_q, first_pend_d;
  logic           overrun_q, overrun_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  chan_q, chan_d;
  logic           stb_q, stb_d;
  logic           first_q, first_d;

  logic [CW-1:0]  rot_idx, low_idx, burst_idx;
  logic           rot_valid, low_valid, burst_valid;

  assign m_eff = (active_mask == '0) ? NCH'(1) : active_mask;

  always_comb begin
    for (int k = 0; k < NCH; k++) ch_in[k] = data_in[k*DW +: DW];
  end

  interleave_next_chan #(.NCH(NCH)) u_rot (
    .mask_i(m_eff), .start_i(ptr_q), .idx_o(rot_idx), .valid_o(rot_valid)
  );

  // Lowest active channel, used to flag the frame start in rotate mode.
  interleave_next_chan #(.NCH(NCH)) u_low (
    .mask_i(m_eff), .start_i('0), .idx_o(low_idx), .valid_o(low_valid)
  );

  interleave_next_chan #(.NCH(NCH)) u_burst (
    .mask_i(rem_q), .start_i('0), .idx_o(burst_idx), .valid_o(burst_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    shadow_d     = shadow_q;
    rem_d        = rem_q;
    rem_left     = rem_q & ~(NCH'(1) << burst_idx);
    first_pend_d = first_pend_q;
    overrun_d    = overrun_q;
    data_d       = data_q;
    chan_d       = chan_q;
    stb_d        = 1'b0;
    first_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (strobe_in && mode == MODE_ROTATE && rot_valid) begin
          data_d  = ch_in[rot_idx];
          chan_d  = rot_idx;
          stb_d   = 1'b1;
          first_d = low_valid && (rot_idx == low_idx);
          ptr_d   = (rot_idx == CW'(NCH - 1)) ? '0 : rot_idx + CW'(1);
        end else if (strobe_in && mode == MODE_BURST) begin
          shadow_d     = ch_in;
          rem_d        = m_eff;
          first_pend_d = 1'b1;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (burst_valid) begin
          data_d       = shadow_q[burst_idx];
          chan_d       = burst_idx;
          stb_d        = 1'b1;
          first_d      = first_pend_q;
          first_pend_d = 1'b0;
          rem_d        = rem_left;
        end
        // A strobe landing on the final emission starts the next burst with
        // no idle clock; mode is not re-sampled while draining.
        if (rem_left == '0) begin
          if (strobe_in) begin
            shadow_d     = ch_in;
            rem_d        = m_eff;
            first_pend_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (strobe_in) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || init || !enable) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      shadow_q     <= '{default: '0};
      rem_q        <= '0;
      first_pend_q <= 1'b0;
      data_q       <= '0;
      chan_q       <= '0;
      stb_q        <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      shadow_q     <= shadow_d;
      rem_q        <= rem_d;
      first_pend_q <= first_pend_d;
      data_q       <= data_d;
      chan_q       <= chan_d;
      stb_q        <= stb_d;
      first_q      <= first_d;
    end
  end

  // Overrun survives enable=0 so software can still read it after a pause.
  always_ff @(posedge clock) begin
    if (reset || init) overrun_q <= 1'b0;
    else if (enable)   overrun_q <= overrun_d;
  end

  assign data_out   = data_q;
  assign chan_out   = chan_q;
  assign strobe_out = stb_q;
  assign first_out  = first_q;
  assign overrun    = overrun_q;

endmodule
